// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared pipeline types, forward-select and result-source encodings.
package hazard_unit_pkg;
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic [4:0] rd_w, input logic wr_m, input logic wr_w);
    return (wr_m && rd_m != 5'd0 && rd_m == rs) ? FWD_M :
           (wr_w && rd_w != 5'd0 && rd_w == rs) ? FWD_W : FWD_RF;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && count != '1) count <= count + 32'd1;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: operand forwarding, load-use and memory-wait stalls, branch flushes, perf counters.
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D_i,
  input  logic [4:0]  Rs2D_i,
  input  logic [4:0]  Rs1E_i,
  input  logic [4:0]  Rs2E_i,
  input  logic [4:0]  RdE_i,
  input  logic [4:0]  RdM_i,
  input  logic [4:0]  RdW_i,
  input  logic        RegWriteM_i,
  input  logic        RegWriteW_i,
  input  logic [1:0]  ResultSrcE_i,
  input  logic        PCSrcE_i,
  input  logic        MemReqM_i,
  input  logic        MemReadyM_i,
  output logic [1:0]  ForwardAE_o,
  output logic [1:0]  ForwardBE_o,
  output logic        StallF_o,
  output logic        StallD_o,
  output logic        StallE_o,
  output logic        StallM_o,
  output logic        FlushD_o,
  output logic        FlushE_o,
  output logic        FlushW_o,
  output logic [31:0] StallCount_o,
  output logic [31:0] FlushCount_o
);
  state_t state, state_nxt;
  logic armed, memwait, lwstall;
  assign ForwardAE_o = fwd_sel(Rs1E_i, RdM_i, RdW_i, RegWriteM_i, RegWriteW_i);
  assign ForwardBE_o = fwd_sel(Rs2E_i, RdM_i, RdW_i, RegWriteM_i, RegWriteW_i);
  // armed masks the first edge after reset release from the stall counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  // the ready cycle releases the pipeline at once; state returns to RUN on the following edge
  always_comb begin
    memwait = !MemReadyM_i && (state == MEM_WAIT || MemReqM_i);
    lwstall = ResultSrcE_i == RESULT_LOAD && RdE_i != 5'd0 && (RdE_i == Rs1D_i || RdE_i == Rs2D_i);
    state_nxt = (state == MEM_WAIT) ? (MemReadyM_i ? RUN : MEM_WAIT)
                                    : ((MemReqM_i && !MemReadyM_i) ? MEM_WAIT : RUN);
    StallF_o = rst_n && (memwait || lwstall);
    StallD_o = rst_n && (memwait || lwstall);
    StallE_o = rst_n && memwait;
    StallM_o = rst_n && memwait;
    FlushD_o = !rst_n || (!memwait && PCSrcE_i);
    FlushE_o = !rst_n || (!memwait && (lwstall || PCSrcE_i));
    FlushW_o = !rst_n || memwait;
  end
  sat_counter u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(StallF_o && armed), .count(StallCount_o));
  sat_counter u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(FlushE_o && PCSrcE_i), .count(FlushCount_o));
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and random stimulus checked cycle by cycle against a behavioural model.
module tb_hazard_unit;
  import hazard_unit_pkg::*;
  logic clk = 1'b0, rst_n;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic wm, ww, pc, req, rdy;
  logic [1:0] rsrc, fwd_a, fwd_b;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [31:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  logic m_wait, m_first;
  logic [31:0] m_stall, m_flush, s0, f0;
  hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
    .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw), .RegWriteM_i(wm), .RegWriteW_i(ww),
    .ResultSrcE_i(rsrc), .PCSrcE_i(pc), .MemReqM_i(req), .MemReadyM_i(rdy),
    .ForwardAE_o(fwd_a), .ForwardBE_o(fwd_b), .StallF_o(stall_f), .StallD_o(stall_d),
    .StallE_o(stall_e), .StallM_o(stall_m), .FlushD_o(flush_d), .FlushE_o(flush_e),
    .FlushW_o(flush_w), .StallCount_o(stall_cnt), .FlushCount_o(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_fwd(input logic [4:0] rs);
    if (wm && rdm == rs && rs != 0) return 32'd2;
    if (ww && rdw == rs && rs != 0) return 32'd1;
    return 32'd0;
  endfunction
  task automatic clear();
    {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
    {wm, ww, pc, req, rdy} = '0;
    rsrc = 2'b00;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    m_wait = 1'b0; m_first = 1'b1; m_stall = '0; m_flush = '0;
  endtask
  task automatic cyc();
    logic mw, lw;
    #1;
    mw = !rdy && (m_wait || req);
    lw = rsrc == 2'b01 && rde != 0 && (rde == rs1d || rde == rs2d);
    chk("fwd_a", {30'd0, fwd_a}, ref_fwd(rs1e));
    chk("fwd_b", {30'd0, fwd_b}, ref_fwd(rs2e));
    chk("stall_f", {31'd0, stall_f}, {31'd0, rst_n & (mw | lw)});
    chk("stall_d", {31'd0, stall_d}, {31'd0, rst_n & (mw | lw)});
    chk("stall_e", {31'd0, stall_e}, {31'd0, rst_n & mw});
    chk("stall_m", {31'd0, stall_m}, {31'd0, rst_n & mw});
    chk("flush_d", {31'd0, flush_d}, {31'd0, !rst_n | (!mw & pc)});
    chk("flush_e", {31'd0, flush_e}, {31'd0, !rst_n | (!mw & (lw | pc))});
    chk("flush_w", {31'd0, flush_w}, {31'd0, !rst_n | mw});
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    chk("state", 32'(dut.state), m_wait ? 32'(MEM_WAIT) : 32'(RUN));
    @(posedge clk);
    if (rst_n) begin
      if (!m_first && (mw || lw) && m_stall != '1) m_stall++;
      if (!mw && pc && m_flush != '1) m_flush++;
      m_wait = m_wait ? !rdy : (req && !rdy);
      m_first = 1'b0;
    end
    @(negedge clk);
  endtask
  initial begin
    clear();
    do_reset();
    rdm = 5'd5; wm = 1'b1; rs1e = 5'd5;
    #2;
    cyc();
    chk("rst_fwd_comb", {30'd0, fwd_a}, 32'd2);
    chk("rst_flush_d", {31'd0, flush_d}, 32'd1);
    chk("rst_cnt", stall_cnt, 32'd0);
    clear();
    rsrc = 2'b01; rde = 5'd7; rs2d = 5'd7;
    rst_n = 1'b1;
    cyc();
    chk("first_edge_no_count", stall_cnt, 32'd0);
    clear();
    rdm = 5'd5; wm = 1'b1; rdw = 5'd5; ww = 1'b1; rs1e = 5'd5;
    cyc();
    chk("fwd_m", {30'd0, fwd_a}, 32'd2);
    rdm = 5'd0;
    cyc();
    chk("fwd_w", {30'd0, fwd_a}, 32'd1);
    clear();
    s0 = m_stall;
    rsrc = 2'b01; rde = 5'd7; rs2d = 5'd7;
    cyc();
    clear();
    cyc();
    chk("loaduse_cnt", stall_cnt, s0 + 32'd1);
    // entry cycle plus three MEM_WAIT cycles stalled, then the ready cycle releases
    s0 = m_stall;
    req = 1'b1; rdy = 1'b0;
    repeat (4) cyc();
    rdy = 1'b1;
    cyc();
    clear();
    cyc();
    chk("memwait_cnt", stall_cnt, s0 + 32'd4);
    chk("memwait_state", 32'(dut.state), 32'(RUN));
    f0 = m_flush;
    req = 1'b1; rdy = 1'b0; pc = 1'b1;
    repeat (3) cyc();
    rdy = 1'b1;
    cyc();
    clear();
    cyc();
    chk("deferred_flush_cnt", flush_cnt, f0 + 32'd1);
    req = 1'b1; rdy = 1'b0;
    cyc();
    cyc();
    do_reset();
    cyc();
    chk("midwait_rst_stall", {31'd0, stall_f}, 32'd0);
    chk("midwait_rst_flush_e", {31'd0, flush_e}, 32'd1);
    clear();
    rst_n = 1'b1;
    cyc();
    chk("midwait_rst_state", 32'(dut.state), 32'(RUN));
    for (int i = 0; i < 400; i++) begin
      rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
      rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
      rde = 5'($urandom_range(0, 3)); rdm = 5'($urandom_range(0, 3)); rdw = 5'($urandom_range(0, 3));
      wm = 1'($urandom); ww = 1'($urandom); rsrc = 2'($urandom);
      pc = ($urandom_range(0, 3) == 0);
      req = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      cyc();
    end
    clear();
    rdy = 1'b1;
    cyc();
    clear();
    force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.count;
    m_stall = 32'hFFFF_FFFE;
    cyc();
    rsrc = 2'b01; rde = 5'd9; rs1d = 5'd9;
    repeat (3) cyc();
    clear();
    cyc();
    chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
